fs_accel_pool_ctrl: RTL and testbench
=====================================

Name: fs_accel_POOL_ctrl

Overview:
- Pipeline-stage controller for the POOL stage of the accelerator pipeline (RDATA -> COMPS -> POOL -> WBACK).
- Consumes the COMPS stage handshake and its pipeline-register outputs.
- Drives the pooling unit and the accumulate-matrix read side.
- Presents POOL_start/POOL_rdy/POOL_fin plus the registered address/quant sideband to WBACK. Advances in lockstep with the other stage controllers.

Parameters:
- ADDR_W, 32, width of ps/o address sideband
- CNT_W, 3, width of pool-window counter (window of up to 2^CNT_W-1 cycles)

Ports:
- clk  in  1  clock
- resetn  in  1  reset; asynchronous, active-low
- enb  in  1  global stage enable; when 0, FSM, counter and pipeline flops hold
- cfg_layer_typ  in  4  0=CONV, 1=DENSE, 2=MIXED; other values treated as DENSE
- cfg_pool_enb  in  1  1=pool on completed outputs, 0=bypass always
- cfg_pool_win  in  CNT_W  pool window length in cycles; 0 treated as 1
- RDATA_rdy, RDATA_fin  in  1 each  RDATA stage status
- COMPS_rdy, COMPS_fin, COMPS_start  in  1 each  COMPS stage status
- COMPS_is_out_fin  in  1  sideband: output tile complete
- COMPS_ps_addr, COMPS_o_addr  in  ADDR_W each  sideband addresses
- COMPS_o_quant_sel  in  4  sideband quant select
- WBACK_rdy, WBACK_start  in  1 each  WBACK stage status
- acc_matrix_rd_enb  out  1  read accumulate matrix this cycle
- pool_enb  out  1  pooling unit compare/accumulate enable
- pool_first  out  1  first window cycle; pool unit reloads instead of compares
- pool_last  out  1  last window cycle
- pool_bypass  out  1  pass accumulator value unpooled
- POOL_start, POOL_rdy, POOL_fin  out  1 each  stage status
- POOL_is_out_fin  out  1  registered sideband
- POOL_ps_addr, POOL_o_addr  out  ADDR_W each  registered sideband
- POOL_o_quant_sel  out  4  registered sideband

Behaviour:
- adv = (RDATA_rdy|RDATA_fin) & (COMPS_rdy|COMPS_fin) & (POOL_rdy|POOL_start) & (WBACK_rdy|WBACK_start) & enb.
- The pipeline flop captures all COMPS_* sideband into POOL_* on adv & COMPS_rdy. COMPS_fin alone never loads.
- Reset (asynchronous): state=P_START, cnt=0, all POOL_* sideband flops = 0.
  - Combinational outputs during reset: POOL_start=1, all others 0.
- Pooling is active when cfg_pool_enb=1 and cfg_layer_typ is CONV or MIXED. DENSE always bypasses.
- States:
  - P_START: POOL_start=1.
    - If adv & COMPS_rdy: load sideband, go to P_RUN, cnt=0.
    - If adv & COMPS_fin & !COMPS_rdy: go to P_FINISH.
  - P_RUN: acc_matrix_rd_enb=1.
    - Bypass case (pooling inactive, or POOL_is_out_fin=0): pool_bypass=1 for exactly 1 cycle, then go to P_WAIT.
    - Pool case: pool_enb=1 for W=max(cfg_pool_win,1) cycles; cnt increments 0..W-1.
      - pool_first=1 when cnt==0; pool_last=1 when cnt==W-1; both are 1 if W=1.
      - At cnt==W-1, go to P_WAIT and set cnt=0.
  - P_WAIT: POOL_rdy=1.
    - On adv: if COMPS_fin, go to P_FINISH. Else load sideband, go to P_RUN, cnt=0.
  - P_FINISH: POOL_fin=1. Terminal until reset.
- Config and pooling-active decision are sampled from the live inputs each cycle. The inputs must be held stable from P_START through P_FINISH.
- enb=0 in P_RUN freezes cnt and state. Outputs still reflect the current state/cnt; the pool unit gates itself on enb.
- Latency: sideband appears on POOL_* the cycle after adv. POOL_rdy rises 1 cycle (bypass) or W cycles (pool) after entering P_RUN.
- COMPS_rdy and COMPS_fin both high at adv in P_WAIT: fin wins (P_FINISH) and the sideband still loads.
- Reset asserted mid-P_RUN: immediate return to P_START. The partial window is discarded and no pool_last is issued.

Test Plan:
- Reset release, all status low -> POOL_start=1, POOL_rdy=0, all POOL_* sideband=0, no enables for 10 cycles.
- CONV, cfg_pool_enb=1, win=4; COMPS delivers is_out_fin=1, o_addr=0x100, all stages ready -> pool_enb high 4 cycles, pool_first on cycle 1, pool_last on cycle 4, POOL_o_addr=0x100, then POOL_rdy=1.
- Same config with is_out_fin=0, ps_addr=0x40 -> single pool_bypass cycle, pool_enb never asserted, POOL_ps_addr=0x40, POOL_rdy next cycle.
- In P_WAIT hold WBACK_rdy=0 for 5 cycles while COMPS_rdy=1 -> POOL_rdy stays 1, sideband unchanged; WBACK_rdy=1 -> new sideband loaded next cycle and P_RUN re-entered.
- DENSE with cfg_pool_enb=1, three items then COMPS_fin=1 -> three bypass cycles, no pool_enb, POOL_fin=1 held after the final adv.
- CONV win=4, assert resetn=0 asynchronously at cnt=2 -> outputs clear without a clock edge, POOL_start=1; after release the sequence restarts with pool_first at cnt=0.

Source files
------------

// File: rtl/fs_accel_pool_ctrl_if.sv
// -----------------------------------------------------------------------------
// fs_accel_pool_ctrl_if
//   Stage handshake and sideband bundle around the POOL stage controller.
//   Carries the upstream stage status (RDATA, COMPS) and the COMPS pipeline
//   register sideband in. It also carries the downstream WBACK status in.
//   It carries the POOL status and the registered POOL sideband out.
//
//   modport master : the POOL controller (consumes status/sideband, drives POOL_*)
//   modport slave  : the surrounding pipeline / environment
// -----------------------------------------------------------------------------
interface fs_accel_pool_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              RDATA_rdy;
  logic              RDATA_fin;
  logic              COMPS_rdy;
  logic              COMPS_fin;
  logic              COMPS_start;
  logic              COMPS_is_out_fin;
  logic [ADDR_W-1:0] COMPS_ps_addr;
  logic [ADDR_W-1:0] COMPS_o_addr;
  logic [3:0]        COMPS_o_quant_sel;
  logic              WBACK_rdy;
  logic              WBACK_start;
  logic              POOL_start;
  logic              POOL_rdy;
  logic              POOL_fin;
  logic              POOL_is_out_fin;
  logic [ADDR_W-1:0] POOL_ps_addr;
  logic [ADDR_W-1:0] POOL_o_addr;
  logic [3:0]        POOL_o_quant_sel;

  modport master (
    input  RDATA_rdy, RDATA_fin,
    input  COMPS_rdy, COMPS_fin, COMPS_start, COMPS_is_out_fin,
    input  COMPS_ps_addr, COMPS_o_addr, COMPS_o_quant_sel,
    input  WBACK_rdy, WBACK_start,
    output POOL_start, POOL_rdy, POOL_fin, POOL_is_out_fin,
    output POOL_ps_addr, POOL_o_addr, POOL_o_quant_sel
  );

  modport slave (
    output RDATA_rdy, RDATA_fin,
    output COMPS_rdy, COMPS_fin, COMPS_start, COMPS_is_out_fin,
    output COMPS_ps_addr, COMPS_o_addr, COMPS_o_quant_sel,
    output WBACK_rdy, WBACK_start,
    input  POOL_start, POOL_rdy, POOL_fin, POOL_is_out_fin,
    input  POOL_ps_addr, POOL_o_addr, POOL_o_quant_sel
  );
endinterface

// File: rtl/fs_accel_pool_ctrl.sv
// -----------------------------------------------------------------------------
// fs_accel_pool_ctrl
//   Stage controller for POOL in the RDATA -> COMPS -> POOL -> WBACK pipeline.
//   All four stage controllers advance together on a common "adv" condition.
//   On each advance that carries a new COMPS item, the COMPS sideband is
//   registered into POOL_*. The item is then run through the pooling unit.
//   The run is either a single bypass cycle, or a W-cycle pool window with
//   first/last markers. After the run the controller waits in a ready state.
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   enb                  global stage enable; 0 freezes FSM, counter, flops
//   cfg_layer_typ        0=CONV, 1=DENSE, 2=MIXED, others behave as DENSE
//   cfg_pool_enb         1 = pool completed output tiles, 0 = always bypass
//   cfg_pool_win         pool window length in cycles (0 behaves as 1)
//   ifc (master)         stage status in, COMPS sideband in, POOL_* out
//   acc_matrix_rd_enb    accumulate-matrix read strobe (every run cycle)
//   pool_enb             pool unit compare/accumulate enable
//   pool_first           first window cycle (pool unit reloads)
//   pool_last            last window cycle
//   pool_bypass          pass accumulator value through unpooled
// -----------------------------------------------------------------------------
module fs_accel_pool_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 3
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                enb,
  input  logic [3:0]          cfg_layer_typ,
  input  logic                cfg_pool_enb,
  input  logic [CNT_W-1:0]    cfg_pool_win,
  fs_accel_pool_ctrl_if.master ifc,
  output logic                acc_matrix_rd_enb,
  output logic                pool_enb,
  output logic                pool_first,
  output logic                pool_last,
  output logic                pool_bypass
);

  typedef enum logic [1:0] {
    P_START  = 2'd0,
    P_RUN    = 2'd1,
    P_WAIT   = 2'd2,
    P_FINISH = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;

  logic              is_out_fin_p1;
  logic [ADDR_W-1:0] ps_addr_p1;
  logic [ADDR_W-1:0] o_addr_p1;
  logic [3:0]        o_quant_sel_p1;

  logic              st_start, st_rdy, st_fin;
  logic              adv, load;
  logic              pool_act, do_pool;
  logic [CNT_W-1:0]  win_eff;
  logic              cnt_last;

  // COMPS_start is part of the stage bundle but plays no role in POOL control.
  logic              unused_comps_start;
  assign unused_comps_start = ifc.COMPS_start;

  // Stage status is a pure decode of the state register, so adv never
  // loops back through the next-state logic.
  assign st_start = (state == P_START);
  assign st_rdy   = (state == P_WAIT);
  assign st_fin   = (state == P_FINISH);

  assign adv  = (ifc.RDATA_rdy | ifc.RDATA_fin) &
                (ifc.COMPS_rdy | ifc.COMPS_fin) &
                (st_rdy        | st_start)      &
                (ifc.WBACK_rdy | ifc.WBACK_start) &
                enb;

  // Any advance that carries a COMPS item loads the sideband, even when
  // COMPS_fin arrives alongside it.
  assign load = adv & ifc.COMPS_rdy;

  // Only CONV and MIXED layers pool; every other type code is DENSE.
  assign pool_act = cfg_pool_enb & ((cfg_layer_typ == 4'd0) | (cfg_layer_typ == 4'd2));
  // Partial output tiles are never pooled; they pass through.
  assign do_pool  = pool_act & is_out_fin_p1;

  assign win_eff  = (cfg_pool_win == '0) ? CNT_W'(1) : cfg_pool_win;
  assign cnt_last = (cnt == (win_eff - CNT_W'(1)));

  // ---- stage p0 -> p1 : COMPS sideband into POOL pipeline register ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      is_out_fin_p1  <= 1'b0;
      ps_addr_p1     <= '0;
      o_addr_p1      <= '0;
      o_quant_sel_p1 <= '0;
    end else if (load) begin
      is_out_fin_p1  <= ifc.COMPS_is_out_fin;
      ps_addr_p1     <= ifc.COMPS_ps_addr;
      o_addr_p1      <= ifc.COMPS_o_addr;
      o_quant_sel_p1 <= ifc.COMPS_o_quant_sel;
    end
  end

  // ---- control state ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= P_START;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    cnt_nxt           = cnt;
    acc_matrix_rd_enb = 1'b0;
    pool_enb          = 1'b0;
    pool_first        = 1'b0;
    pool_last         = 1'b0;
    pool_bypass       = 1'b0;
    case (state)
      P_START: begin
        if (load) begin
          state_nxt = P_RUN;
          cnt_nxt   = '0;
        end else if (adv & ifc.COMPS_fin) begin
          state_nxt = P_FINISH;
        end
      end
      P_RUN: begin
        acc_matrix_rd_enb = 1'b1;
        if (!do_pool) begin
          pool_bypass = 1'b1;
          if (enb) state_nxt = P_WAIT;
        end else begin
          pool_enb   = 1'b1;
          pool_first = (cnt == '0);
          pool_last  = cnt_last;
          if (enb) begin
            if (cnt_last) begin
              state_nxt = P_WAIT;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end
        end
      end
      P_WAIT: begin
        if (adv) begin
          if (ifc.COMPS_fin) begin
            state_nxt = P_FINISH;
          end else begin
            state_nxt = P_RUN;
            cnt_nxt   = '0;
          end
        end
      end
      P_FINISH: begin
        state_nxt = P_FINISH;
      end
      default: begin
        state_nxt = P_START;
      end
    endcase
  end

  assign ifc.POOL_start       = st_start;
  assign ifc.POOL_rdy         = st_rdy;
  assign ifc.POOL_fin         = st_fin;
  assign ifc.POOL_is_out_fin  = is_out_fin_p1;
  assign ifc.POOL_ps_addr     = ps_addr_p1;
  assign ifc.POOL_o_addr      = o_addr_p1;
  assign ifc.POOL_o_quant_sel = o_quant_sel_p1;

endmodule

// File: tb/tb_fs_accel_pool_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fs_accel_pool_ctrl
//   Scoreboard bench for the POOL stage controller. The driver offers COMPS
//   items and, whenever an item is accepted, pushes the expected run
//   (bypass or a W-cycle window) and the expected POOL sideband into a queue.
//   A monitor watches the pooling outputs and POOL status. It pops one entry
//   per observed run or finish, and compares the two.
// -----------------------------------------------------------------------------
module tb_fs_accel_pool_ctrl;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 3;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             enb = 1'b0;
  logic [3:0]       cfg_layer_typ = 4'd0;
  logic             cfg_pool_enb = 1'b0;
  logic [CNT_W-1:0] cfg_pool_win = '0;
  logic             acc_matrix_rd_enb, pool_enb, pool_first, pool_last, pool_bypass;

  fs_accel_pool_ctrl_if #(.ADDR_W(ADDR_W)) ifc ();

  fs_accel_pool_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .enb               (enb),
    .cfg_layer_typ     (cfg_layer_typ),
    .cfg_pool_enb      (cfg_pool_enb),
    .cfg_pool_win      (cfg_pool_win),
    .ifc               (ifc),
    .acc_matrix_rd_enb (acc_matrix_rd_enb),
    .pool_enb          (pool_enb),
    .pool_first        (pool_first),
    .pool_last         (pool_last),
    .pool_bypass       (pool_bypass)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         fin;
    bit         byp;
    int         w;
    logic [68:0] sb;
  } exp_t;

  exp_t        sbq[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  bit          all_rdy = 1'b0;
  logic [68:0] model_sb = '0;

  task automatic check(input string nm, input logic [95:0] act, input logic [95:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
  endtask

  function automatic logic [68:0] dut_sb();
    return {ifc.POOL_is_out_fin, ifc.POOL_ps_addr, ifc.POOL_o_addr, ifc.POOL_o_quant_sel};
  endfunction

  // Reference rule: pooling happens only on complete tiles of CONV/MIXED layers
  // with pooling enabled; window length is the configured one, minimum 1.
  function automatic bit model_bypass(input logic iof);
    bit act;
    act = cfg_pool_enb && (cfg_layer_typ == 4'd0 || cfg_layer_typ == 4'd2);
    return !(act && iof);
  endfunction

  function automatic int model_win();
    return (cfg_pool_win == 0) ? 1 : int'(cfg_pool_win);
  endfunction

  // ---------------- monitor ----------------
  bit          in_run = 0, fin_seen = 0, have_last = 0;
  int          r_len, r_enb, r_byp;
  logic [7:0]  r_fm, r_lm;
  logic [68:0] r_sb, last_sb;

  always @(negedge clk) begin
    exp_t e;
    int   elen;
    if (!resetn) begin
      in_run    = 0;
      fin_seen  = 0;
      have_last = 0;
    end else begin
      if (acc_matrix_rd_enb) begin
        if (!in_run) begin
          in_run = 1; r_len = 0; r_enb = 0; r_byp = 0; r_fm = '0; r_lm = '0;
          r_sb = dut_sb();
        end
        if (enb) begin
          if (r_len < 8) begin
            if (pool_first) r_fm[r_len] = 1'b1;
            if (pool_last)  r_lm[r_len] = 1'b1;
          end
          r_enb += int'(pool_enb);
          r_byp += int'(pool_bypass);
          r_len++;
        end
      end else if (in_run) begin
        in_run = 0;
        check("rdy_after_run", ifc.POOL_rdy, 1);
        check("run_expected", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          check("run_not_fin", e.fin, 0);
          elen = e.byp ? 1 : e.w;
          check("run_len", r_len, elen);
          check("run_pool_enb_cycles", r_enb, e.byp ? 0 : e.w);
          check("run_bypass_cycles", r_byp, e.byp ? 1 : 0);
          check("run_first_pos", r_fm, e.byp ? 8'h00 : 8'h01);
          check("run_last_pos", r_lm, e.byp ? 8'h00 : (8'h01 << (e.w - 1)));
          check("run_sideband", r_sb, e.sb);
          last_sb   = e.sb;
          have_last = 1;
        end
      end
      if (ifc.POOL_rdy && have_last) check("wait_sideband_hold", dut_sb(), last_sb);
      if (ifc.POOL_fin && !fin_seen) begin
        fin_seen = 1;
        check("fin_expected", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          check("fin_kind", e.fin, 1);
          check("fin_sideband", dut_sb(), e.sb);
        end
      end else if (fin_seen) begin
        check("fin_held", {ifc.POOL_fin, acc_matrix_rd_enb, ifc.POOL_rdy}, 3'b100);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic rand_status();
    if (all_rdy) begin
      ifc.RDATA_rdy = 1; ifc.RDATA_fin = 0; ifc.WBACK_rdy = 1; ifc.WBACK_start = 0; enb = 1;
    end else begin
      ifc.RDATA_rdy   = ($urandom_range(0, 3) != 0);
      ifc.RDATA_fin   = ($urandom_range(0, 7) == 0);
      ifc.WBACK_rdy   = ($urandom_range(0, 3) != 0);
      ifc.WBACK_start = ($urandom_range(0, 7) == 0);
      enb             = ($urandom_range(0, 5) != 0);
    end
    ifc.COMPS_start = $urandom_range(0, 1);
  endtask

  task automatic do_reset();
    resetn = 0;
    sbq.delete();
    model_sb = '0;
    ifc.COMPS_rdy = 0; ifc.COMPS_fin = 0;
    repeat (2) @(posedge clk);
    #1 resetn = 1;
  endtask

  task automatic idle(input int n);
    ifc.COMPS_rdy = 0; ifc.COMPS_fin = 0;
    repeat (n) begin rand_status(); @(posedge clk); #1; end
  endtask

  // Offer one COMPS transfer until the pipeline advances on it.
  task automatic issue(input bit rdy, input bit fin, input logic iof,
                       input logic [31:0] ps, input logic [31:0] oa, input logic [3:0] qs);
    exp_t e;
    bit   ok = 0;
    int   n = 0;
    ifc.COMPS_rdy = rdy; ifc.COMPS_fin = fin;
    ifc.COMPS_is_out_fin = iof; ifc.COMPS_ps_addr = ps;
    ifc.COMPS_o_addr = oa; ifc.COMPS_o_quant_sel = qs;
    while (!ok && n < 300) begin
      rand_status();
      @(negedge clk);
      if ((ifc.RDATA_rdy | ifc.RDATA_fin) & (ifc.COMPS_rdy | ifc.COMPS_fin) &
          (ifc.POOL_rdy | ifc.POOL_start) & (ifc.WBACK_rdy | ifc.WBACK_start) & enb) begin
        ok = 1;
        if (rdy) model_sb = {iof, ps, oa, qs};
        e.fin = fin;
        e.byp = model_bypass(iof);
        e.w   = model_win();
        e.sb  = model_sb;
        sbq.push_back(e);
      end
      @(posedge clk); #1;
      n++;
    end
    ifc.COMPS_rdy = 0; ifc.COMPS_fin = 0;
    check("accept_in_time", ok, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 300) begin
      idle(1);
      n++;
    end
    idle(2);
    check("queue_drained", sbq.size(), 0);
  endtask

  task automatic set_cfg(input logic [3:0] typ, input logic pen, input logic [CNT_W-1:0] win);
    cfg_layer_typ = typ; cfg_pool_enb = pen; cfg_pool_win = win;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    ifc.RDATA_rdy = 0; ifc.RDATA_fin = 0; ifc.COMPS_rdy = 0; ifc.COMPS_fin = 0;
    ifc.COMPS_start = 0; ifc.COMPS_is_out_fin = 0; ifc.COMPS_ps_addr = '0;
    ifc.COMPS_o_addr = '0; ifc.COMPS_o_quant_sel = '0; ifc.WBACK_rdy = 0; ifc.WBACK_start = 0;
    set_cfg(4'd0, 1'b1, 3'd4);
    #3;
    check("in_reset_start", {ifc.POOL_start, ifc.POOL_rdy, ifc.POOL_fin}, 3'b100);

    // Reset release with every stage idle: stays in start, nothing enabled.
    resetn = 0;
    repeat (2) @(posedge clk);
    #1 resetn = 1; enb = 1;
    repeat (10) begin
      @(negedge clk);
      check("idle_status", {ifc.POOL_start, ifc.POOL_rdy, ifc.POOL_fin, acc_matrix_rd_enb,
                            pool_enb, pool_first, pool_last, pool_bypass}, 8'b1000_0000);
      check("idle_sideband", dut_sb(), 69'd0);
    end
    @(posedge clk); #1;

    // CONV window of 4 on a complete tile, then a partial tile bypass.
    all_rdy = 1;
    issue(1, 0, 1, 32'h0000_0010, 32'h0000_0100, 4'd3);
    issue(1, 0, 0, 32'h0000_0040, 32'h0000_0200, 4'd5);
    idle(1);
    check("wait_after_bypass", ifc.POOL_rdy, 1);

    // WBACK stalls for 5 cycles while COMPS offers a new item.
    ifc.COMPS_rdy = 1; ifc.COMPS_fin = 0; ifc.COMPS_is_out_fin = 1;
    ifc.COMPS_ps_addr = 32'hAAAA_0000; ifc.COMPS_o_addr = 32'h0000_0300; ifc.COMPS_o_quant_sel = 4'd9;
    ifc.WBACK_rdy = 0; ifc.WBACK_start = 0;
    repeat (5) begin
      @(negedge clk);
      check("stall_rdy", ifc.POOL_rdy, 1);
      check("stall_sideband", ifc.POOL_ps_addr, 32'h0000_0040);
      @(posedge clk); #1;
    end
    issue(1, 0, 1, 32'hAAAA_0000, 32'h0000_0300, 4'd9);
    // fin together with rdy: finish wins, sideband still loads.
    issue(1, 1, 0, 32'hBBBB_0000, 32'h0000_0400, 4'd1);
    drain();

    // DENSE with pooling enabled: three bypasses, then finish.
    do_reset();
    set_cfg(4'd1, 1'b1, 3'd4);
    for (int i = 0; i < 3; i++) issue(1, 0, 1, 32'h1000 + i, 32'h2000 + i, 4'(i));
    issue(0, 1, 0, 32'h0, 32'h0, 4'd0);
    drain();

    // Randomized blocks under random stalls and enable gaps.
    all_rdy = 0;
    for (int b = 0; b < 30; b++) begin
      int n_items;
      do_reset();
      set_cfg(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 3) == 0) cfg_layer_typ = 4'd0;
      n_items = $urandom_range(0, 5);
      for (int i = 0; i < n_items; i++) begin
        issue(1, 0, 1'($urandom_range(0, 3) != 0), $urandom, $urandom, 4'($urandom_range(0, 15)));
        idle($urandom_range(0, 2));
      end
      issue((n_items != 0) && ($urandom_range(0, 1) == 1), 1, 1'($urandom_range(0, 1)),
            $urandom, $urandom, 4'($urandom_range(0, 15)));
      drain();
    end

    // Asynchronous reset in the middle of a window.
    all_rdy = 1;
    do_reset();
    set_cfg(4'd0, 1'b1, 3'd4);
    issue(1, 0, 1, 32'h0000_0077, 32'h0000_0500, 4'd2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_window_cnt2", {acc_matrix_rd_enb, pool_enb, pool_first, pool_last}, 4'b1100);
    #2;
    resetn = 0;
    sbq.delete();
    model_sb = '0;
    #1;
    check("async_reset_status", {ifc.POOL_start, ifc.POOL_rdy, ifc.POOL_fin, acc_matrix_rd_enb,
                                 pool_enb, pool_first, pool_last, pool_bypass}, 8'b1000_0000);
    check("async_reset_sideband", dut_sb(), 69'd0);
    @(posedge clk); #1;
    resetn = 1;
    issue(1, 0, 1, 32'h0000_0078, 32'h0000_0600, 4'd4);
    issue(0, 1, 0, 32'h0, 32'h0, 4'd0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
